// File: rtl/cmp_arbiter.sv
// Shares one ALU comparator between the branch unit (req0) and the set-on-compare
// writeback path (req1). Define CMP_ARB_FIXED_PRIO_EN for fixed req0 priority.
module cmp_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_start,
  output logic             aluop3,
  output logic             aluop1,
  input  logic [WIDTH-1:0] compout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

  state_t     state;
  logic [1:0] wait_cnt;
  logic       owner;
  logic       contested_pick;
  logic       pick1;
  logic       accept;

`ifdef CMP_ARB_FIXED_PRIO_EN
  assign contested_pick = 1'b0;
`else
  logic last_grant;

  // Resetting to 1 makes req0 the first contested winner.
  always_ff @(posedge clk) begin
    if (!reset_n)           last_grant <= 1'b1;
    else if (state == RESP) last_grant <= owner;
  end

  assign contested_pick = ~last_grant;
`endif

  always_comb begin
    if (req0_valid && req1_valid) pick1 = contested_pick;
    else                          pick1 = req1_valid;
  end

  // NOTE: ready is combinational; gating with reset_n keeps it low while reset is held.
  assign accept     = reset_n && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !pick1;
  assign req1_ready = accept && pick1;
  assign busy       = (state != IDLE);

  // NOTE: every register here uses <= so all state advances together on the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      owner       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      aluop3      <= 1'b0;
      aluop1      <= 1'b0;
      alu_start   <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp1_result <= '0;
    end else begin
      alu_start  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner     <= pick1;
            alu_a     <= pick1 ? req1_a : req0_a;
            alu_b     <= pick1 ? req1_b : req0_b;
            aluop3    <= pick1 ? req1_op[1] : req0_op[1];
            aluop1    <= pick1 ? req1_op[0] : req0_op[0];
            alu_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= CNT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (owner) begin
              rsp1_result <= compout;
              rsp1_valid  <= 1'b1;
            end else begin
              rsp0_result <= compout;
              rsp0_valid  <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: vector table + scoreboard on an ALU_LAT=1 instance,
// plus a short sequence on an ALU_LAT=3 instance. Honours CMP_ARB_FIXED_PRIO_EN.
`timescale 1ns/1ps
module tb_cmp_arbiter;
  localparam int W      = 32;
  localparam int LAT    = 1;
  localparam int LAT3   = 3;
  localparam int BUDGET = 60;
  localparam logic [W-1:0] JUNK = 32'hA5A5_A5A5;

  typedef struct {
    logic         port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic         owner;
    logic [W-1:0] result;
    int           cyc;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic rsp0_valid, rsp1_valid, alu_start, aluop3, aluop1, busy;
  logic [W-1:0] rsp0_result, rsp1_result, alu_a, alu_b;
  logic [W-1:0] compout = JUNK;

  logic l3_valid, l3_ready, l3_req0_ready;
  logic [W-1:0] l3_a, l3_b;
  logic [1:0] l3_op;
  logic l3_rsp0_valid, l3_rsp1_valid, l3_alu_start, l3_aluop3, l3_aluop1, l3_busy;
  logic [W-1:0] l3_rsp0_result, l3_rsp1_result, l3_alu_a, l3_alu_b;
  logic [W-1:0] l3_compout = JUNK;

  cmp_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start), .aluop3(aluop3), .aluop1(aluop1),
    .compout(compout), .busy(busy)
  );

  cmp_arbiter #(.WIDTH(W), .ALU_LAT(LAT3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(1'b0), .req0_ready(l3_req0_ready), .req0_a('0), .req0_b('0), .req0_op(2'b00),
    .req1_valid(l3_valid), .req1_ready(l3_ready), .req1_a(l3_a), .req1_b(l3_b), .req1_op(l3_op),
    .rsp0_valid(l3_rsp0_valid), .rsp0_result(l3_rsp0_result), .rsp1_valid(l3_rsp1_valid), .rsp1_result(l3_rsp1_result),
    .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_start(l3_alu_start), .aluop3(l3_aluop3), .aluop1(l3_aluop1),
    .compout(l3_compout), .busy(l3_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] cmp_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
    case (op)
      2'b00:   return W'(a == b);
      2'b01:   return W'($signed(a) < $signed(b));
      2'b10:   return W'($signed(a) <= $signed(b));
      default: return '0;
    endcase
  endfunction

  // Comparator models: result is valid only in the cycle LAT after alu_start, junk otherwise.
  int st_cyc = -100;
  int st3_cyc = -100;
  always @(negedge clk) if (alu_start) st_cyc = cyc;
  always @(negedge clk) if (l3_alu_start) st3_cyc = cyc;
  always @(posedge clk) begin
    #1;
    compout    = (cyc == st_cyc + LAT) ? cmp_model(alu_a, alu_b, {aluop3, aluop1}) : JUNK;
    l3_compout = (cyc == st3_cyc + LAT3) ? cmp_model(l3_alu_a, l3_alu_b, {l3_aluop3, l3_aluop1}) : JUNK;
  end

  // Scoreboard and protocol monitor for the ALU_LAT=1 instance.
  sb_t sb_q[$];
  int grant_q[$];
  int gcyc_q[$];
  logic mon_en = 1'b0;
  logic acc_valid = 1'b0;
  int acc_cyc = 0;
  logic [W-1:0] acc_a = '0, acc_b = '0;
  logic [1:0] acc_op = '0;
  logic [W-1:0] exp0 = '0, exp1 = '0, hold0 = '0, hold1 = '0;
  logic busy_exp, start_exp, mon_owner;
  sb_t mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!reset_n) begin
        sb_q.delete();
        acc_valid = 1'b0;
        acc_a = '0; acc_b = '0; acc_op = '0;
        hold0 = '0; hold1 = '0;
      end else begin
        busy_exp  = acc_valid && (cyc > acc_cyc) && (cyc <= acc_cyc + LAT + 2);
        start_exp = acc_valid && (cyc == acc_cyc + 1);
        check("busy", busy, busy_exp);
        check("alu_start", alu_start, start_exp);
        if (start_exp) begin
          check("alu_a", alu_a, acc_a);
          check("alu_b", alu_b, acc_b);
          check("aluop", {aluop3, aluop1}, acc_op);
        end
        if (busy_exp) begin
          check("ready_while_busy", {req0_ready, req1_ready}, 0);
        end else if (req0_ready || req1_ready) begin
          check("ready_onehot", req0_ready & req1_ready, 0);
          mon_owner    = req1_ready;
          mon_e.owner  = mon_owner;
          mon_e.result = mon_owner ? exp1 : exp0;
          mon_e.cyc    = cyc;
          sb_q.push_back(mon_e);
          grant_q.push_back(int'(mon_owner));
          gcyc_q.push_back(cyc);
          acc_valid = 1'b1;
          acc_cyc   = cyc;
          acc_a     = mon_owner ? req1_a : req0_a;
          acc_b     = mon_owner ? req1_b : req0_b;
          acc_op    = mon_owner ? req1_op : req0_op;
        end
        if (rsp0_valid || rsp1_valid) begin
          check("rsp_onehot", rsp0_valid & rsp1_valid, 0);
          if (sb_q.size() == 0) begin
            check("rsp_unexpected", {rsp0_valid, rsp1_valid}, 0);
          end else begin
            mon_e = sb_q.pop_front();
            check("rsp_owner", rsp1_valid, mon_e.owner);
            check("rsp_result", mon_e.owner ? rsp1_result : rsp0_result, mon_e.result);
            check("rsp_latency", cyc - mon_e.cyc, LAT + 2);
            if (mon_e.owner) hold1 = mon_e.result;
            else             hold0 = mon_e.result;
          end
        end
      end
    end
  end

  task automatic release_port(input logic port);
    if (port) begin req1_valid = 1'b0; req1_a = JUNK; req1_b = JUNK; req1_op = 2'b11; end
    else      begin req0_valid = 1'b0; req0_a = JUNK; req0_b = JUNK; req0_op = 2'b11; end
  endtask

  task automatic drive(input vec_t v);
    if (v.port) begin req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op; exp1 = v.exp; end
    else        begin req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op; exp0 = v.exp; end
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input vec_t v);
    int n = 0;
    drive(v);
    do begin @(negedge clk); n++; end
    while (!(v.port ? req1_ready : req0_ready) && n < BUDGET);
    check(v.port ? "accept1" : "accept0", v.port ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    release_port(v.port);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < BUDGET) begin @(negedge clk); n++; end
    check("drain_pending", sb_q.size(), 0);
    check("drain_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, {req0_ready, req1_ready}, 0);
    check({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid}, 0);
    check({tag, "_rsp0_result"}, rsp0_result, 0);
    check({tag, "_rsp1_result"}, rsp1_result, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_start_op"}, {alu_start, aluop3, aluop1}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic lat3_run(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic [W-1:0] exp);
    int n = 0;
    int t;
    l3_valid = 1'b1; l3_a = a; l3_b = b; l3_op = op;
    do begin @(negedge clk); n++; end while (!l3_ready && n < BUDGET);
    check("l3_accept", l3_ready, 1);
    check("l3_req0_ready", l3_req0_ready, 0);
    t = cyc;
    @(posedge clk); #1;
    l3_valid = 1'b0; l3_a = JUNK; l3_b = JUNK; l3_op = 2'b11;
    @(negedge clk);
    check("l3_alu_start", l3_alu_start, 1);
    check("l3_aluop", {l3_aluop3, l3_aluop1}, op);
    check("l3_alu_a", l3_alu_a, a);
    check("l3_alu_b", l3_alu_b, b);
    n = 0;
    do begin @(negedge clk); n++; end while (!l3_rsp1_valid && n < BUDGET);
    check("l3_rsp1_valid", l3_rsp1_valid, 1);
    check("l3_latency", cyc - t, LAT3 + 2);
    check("l3_result", l3_rsp1_result, exp);
    check("l3_rsp0_valid", l3_rsp0_valid, 0);
    @(negedge clk);
    check("l3_rsp1_pulse", l3_rsp1_valid, 0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];
  int   exp_order[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb;
    int n;
    vecs[0] = '{1'b0, 32'd5,         32'd5,         2'b00, 32'd1};
    vecs[1] = '{1'b1, 32'd5,         32'd6,         2'b00, 32'd0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFE, 32'd3,         2'b01, 32'd1};
    vecs[3] = '{1'b1, 32'd3,         32'hFFFF_FFFE, 2'b01, 32'd0};
    vecs[4] = '{1'b0, 32'd7,         32'd7,         2'b10, 32'd1};
    vecs[5] = '{1'b1, 32'd8,         32'd7,         2'b10, 32'd0};
    vecs[6] = '{1'b0, 32'd7,         32'd7,         2'b11, 32'd0};
    vecs[7] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b01, 32'd1};
`ifdef CMP_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    reset_n = 1'b0;
    release_port(1'b0);
    release_port(1'b1);
    l3_valid = 1'b0; l3_a = '0; l3_b = '0; l3_op = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Contention straight out of reset: both requesters held valid.
    va = '{1'b0, 32'd1, 32'd2, 2'b01, 32'd1};
    vb = '{1'b1, 32'd9, 32'd3, 2'b10, 32'd0};
    grant_q.delete(); gcyc_q.delete();
    drive(va); drive(vb);
    n = 0;
    while (grant_q.size() < 4 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    release_port(1'b0); release_port(1'b1);
    check("contention_grants", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      check($sformatf("grant%0d", i), grant_q[i], exp_order[i]);
    for (int i = 1; i < 4 && i < gcyc_q.size(); i++)
      check($sformatf("grant_gap%0d", i), gcyc_q[i] - gcyc_q[i-1], LAT + 3);
    wait_idle();

    // Vector table, one operation at a time.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i]);
      wait_idle();
      check($sformatf("v%0d_rsp0_hold", i), rsp0_result, hold0);
      check($sformatf("v%0d_rsp1_hold", i), rsp1_result, hold1);
      check($sformatf("v%0d_alu_a_hold", i), alu_a, acc_a);
    end

    // req1 raised while req0's operation is in flight.
    va = '{1'b0, 32'd4, 32'd9, 2'b01, 32'd1};
    vb = '{1'b1, 32'd6, 32'd6, 2'b10, 32'd1};
    grant_q.delete(); gcyc_q.delete();
    fork
      send(va);
      begin @(posedge clk); #1; send(vb); end
    join
    wait_idle();
    check("bp_grants", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      check("bp_order", {grant_q[0][0], grant_q[1][0]}, 2'b01);
      check("bp_gap", gcyc_q[1] - gcyc_q[0], LAT + 3);
    end

    // Reset during WAIT drops the operation; a pending req1 goes first after release.
    va = '{1'b0, 32'd10, 32'd10, 2'b00, 32'd1};
    vb = '{1'b1, 32'd2,  32'd2,  2'b00, 32'd1};
    send(va);
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(vb);
    @(negedge clk);
    check("rst_wait_ready1", req1_ready, 0);
    @(negedge clk);
    check_zero("rst_mid");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_first_idle_accept", req1_ready, 1);
    @(posedge clk); #1;
    release_port(1'b1);
    wait_idle();
    check("rst_rsp0_hold", rsp0_result, 0);
    check("rst_rsp1_hold", rsp1_result, 1);

    // ALU_LAT=3 instance: lt then le, plus a false le.
    lat3_run(32'hFFFF_FFFE, 32'd3, 2'b01, 32'd1);
    lat3_run(32'd7,         32'd7, 2'b10, 32'd1);
    lat3_run(32'd9,         32'd3, 2'b10, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shares the single ALU-flag comparator (cmpeq / cmplt / cmple) between two requesters: requester 0 is the branch unit and requester 1 is the set-on-compare writeback path. The block arbitrates between the two, latches the operands, drives the ALU operands and comparator op-select, and waits the ALU flag latency. It then captures the 32-bit compare result and returns it to the requester that owns the operation. It sits between the decode/issue logic and the shared ALU + comparator datapath.

## Interface
Parameters:
- WIDTH, 32, operand and result width.
- ALU_LAT, 1, number of cycles from the alu_start cycle to a valid compout. Legal range is 1..4.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle; combinational.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  compare operands.
- req0_op / req1_op  in  2  compare op: 00 = cmpeq, 01 = cmplt, 10 = cmple, 11 = reserved.
- rsp0_valid / rsp1_valid  out  1  one-cycle result pulse.
- rsp0_result / rsp1_result  out  WIDTH  registered compare result.
- alu_a, alu_b  out  WIDTH  operands to the ALU subtractor.
- alu_start  out  1  one-cycle pulse that launches the subtraction.
- aluop3, aluop1  out  1  comparator op-select; equal to {op[1], op[0]}.
- compout  in  WIDTH  comparator output; valid ALU_LAT cycles after alu_start.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - A grant is computed only if at least one reqN_valid is high.
  - If both are valid, the round-robin pointer decides: the requester not granted last wins.
  - The winner's reqN_ready is driven high in the same cycle. The loser's ready stays low.
  - On acceptance the block latches a, b, op and the owner id, then goes to ISSUE.
- ISSUE: alu_start = 1 for exactly one cycle, then WAIT. The wait counter is loaded with ALU_LAT−1.
- WAIT: the counter decrements each cycle. When it reaches 0, compout is sampled into the result register and the state goes to RESP.
- RESP:
  - rsp<owner>_valid = 1 for one cycle, and rsp<owner>_result holds the captured value.
  - The round-robin pointer is updated to the owner.
  - The state returns to IDLE.
- Ready rules:
  - reqN_ready is never high outside IDLE.
  - Requests that arrive while busy stay pending. Requesters must hold valid and operands until ready.
- Output holding:
  - alu_a, alu_b, aluop3 and aluop1 hold the latched values from ISSUE until the next acceptance. They are stable for the whole operation.
  - rspN_result holds its last value between pulses.
- Reserved op 11 is issued normally. The comparator returns 0, and the response is result 0 with a normal pulse.
- There is no response backpressure: a requester must take rsp in its pulse cycle.

## Timing
- Acceptance in cycle T.
- alu_start is high in cycle T+1.
- compout is sampled at the end of cycle T+1+ALU_LAT.
- rsp_valid is high in cycle T+2+ALU_LAT, so accept-to-response latency is ALU_LAT+2.
- The next acceptance is possible at T+3+ALU_LAT at the earliest, so the minimum issue interval is ALU_LAT+3 cycles.
- Reset value of every output is 0. After reset the round-robin pointer favours req0 for the first contested grant.
- Reset asserted mid-operation: the in-flight operation is dropped with no response pulse, the state goes to IDLE, and all outputs return to 0 on the next edge.
- A request that is valid in the RESP cycle is not accepted until the following IDLE cycle.

## Configuration
- CMP_ARB_FIXED_PRIO_EN defined: fixed priority, so req0 always wins a contested grant and the round-robin pointer is removed.
- Macro undefined (default): round-robin arbitration as described above.
- All other behaviour and timing are identical with and without the macro.

## Test plan
- Single eq, ALU_LAT=1:
  - Stimulus: req0 with a=5, b=5, op=00; the comparator model returns compout=1 one cycle after alu_start.
  - Expected: req0_ready pulses at T; alu_start at T+1 with aluop3/aluop1 = 0/0; rsp0_valid at T+3 with result 1; busy high T+1..T+3.
- Contention, round-robin:
  - Stimulus: req0 and req1 held valid continuously from reset.
  - Expected grant order 0, 1, 0, 1. With CMP_ARB_FIXED_PRIO_EN defined, req0 is granted four times in a row and req1 never.
- lt and le, ALU_LAT=3:
  - Stimulus: req1 a=−2, b=3, op=01, with the model returning 1; then req1 a=7, b=7, op=10, with the model returning 1.
  - Expected: aluop3/aluop1 = 0/1, then 1/0; each rsp1_valid arrives 5 cycles after its acceptance with result 1.
- Reserved op:
  - Stimulus: req0 op=11, model returns 0.
  - Expected: rsp0_valid pulses with result 0 at the normal latency.
- Reset mid-operation:
  - Stimulus: reset_n low during the WAIT state.
  - Expected: no rsp pulse; all outputs are 0 the next cycle; after release, a pending req1 is accepted in the first IDLE cycle.
- Busy backpressure:
  - Stimulus: req1 asserted during req0's operation.
  - Expected: req1_ready stays low until IDLE; req1's operands and op are captured unchanged and its response is correct.
